// File: rtl/exe_mem_stage_if.sv
// Data-memory request/response channel between the EXE/MEM stage and the bus wrapper.
// The master side is the pipeline stage; the slave side is the memory bus wrapper.
interface exe_mem_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              dm_req_valid_o;
    logic              dm_req_ready_i;
    logic [ADDR_W-1:0] dm_addr_o;
    logic              dm_we_o;
    logic [3:0]        dm_wstrb_o;
    logic [DATA_W-1:0] dm_wdata_o;
    logic              dm_rsp_valid_i;
    logic [DATA_W-1:0] dm_rdata_i;

    modport master (
        output dm_req_valid_o, dm_addr_o, dm_we_o, dm_wstrb_o, dm_wdata_o,
        input  dm_req_ready_i, dm_rsp_valid_i, dm_rdata_i
    );

    modport slave (
        input  dm_req_valid_o, dm_addr_o, dm_we_o, dm_wstrb_o, dm_wdata_o,
        output dm_req_ready_i, dm_rsp_valid_i, dm_rdata_i
    );
endinterface

// File: rtl/exe_mem_stage.sv
// EXE/MEM pipeline stage: captures EXE results, runs loads/stores over the dm channel,
// formats load data and retires one instruction per cycle towards MEM/WB.
module exe_mem_stage #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  exe_valid_i,
    output logic                  exe_ready_o,
    input  logic [DATA_W-1:0]     exe_alu_result_i,
    input  logic [DATA_W-1:0]     exe_store_data_i,
    input  logic [REG_ADDR_W-1:0] exe_rd_i,
    input  logic                  exe_reg_write_i,
    input  logic                  exe_mem_read_i,
    input  logic                  exe_mem_write_i,
    input  logic [2:0]            exe_funct3_i,
    exe_mem_stage_if.master       dm,
    output logic                  wb_valid_o,
    output logic                  wb_reg_write_o,
    output logic [REG_ADDR_W-1:0] wb_rd_o,
    output logic [DATA_W-1:0]     wb_data_o,
    output logic                  stall_o
);

    typedef enum logic [1:0] {IDLE, WB, REQ, RSP} state_t;

    state_t                r_state;
    logic [DATA_W-1:0]     r_alu;
    logic [DATA_W-1:0]     r_sdata;
    logic [DATA_W-1:0]     r_wb_data;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_reg_write;
    logic                  r_is_store;
    logic [2:0]            r_funct3;

    logic                  w_capture;
    logic [1:0]            w_off;
    logic [3:0]            w_wstrb;
    logic [DATA_W-1:0]     w_wdata;
    logic [DATA_W-1:0]     w_shifted;
    logic [DATA_W-1:0]     w_load_data;

    assign exe_ready_o    = (r_state == IDLE) || (r_state == WB);
    assign stall_o        = (r_state == REQ) || (r_state == RSP);
    assign wb_valid_o     = (r_state == WB);
    assign wb_reg_write_o = wb_valid_o && r_reg_write && (r_rd != '0);
    assign wb_rd_o        = r_rd;
    assign wb_data_o      = r_wb_data;

    assign w_capture = exe_valid_i && exe_ready_o && !flush_i;
    assign w_off     = r_alu[1:0];

    assign dm.dm_req_valid_o = (r_state == REQ);
    assign dm.dm_addr_o      = {r_alu[ADDR_W-1:2], 2'b00};
    assign dm.dm_we_o        = r_is_store;
    assign dm.dm_wstrb_o     = r_is_store ? w_wstrb : '0;
    assign dm.dm_wdata_o     = w_wdata;

    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = r_sdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << w_off;
                w_wdata = {4{r_sdata[7:0]}};
            end
            2'b01: begin
                w_wstrb = 4'b0011 << {w_off[1], 1'b0};
                w_wdata = {2{r_sdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Byte loads shift by the full offset, halfwords by off[1] only, words not at all.
    always_comb begin
        w_shifted = dm.dm_rdata_i;
        case (r_funct3[1:0])
            2'b00:   w_shifted = dm.dm_rdata_i >> {w_off, 3'b000};
            2'b01:   w_shifted = dm.dm_rdata_i >> {w_off[1], 4'b0000};
            default: ;
        endcase
        case (r_funct3)
            3'b000:  w_load_data = {{(DATA_W-8){w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load_data = {{(DATA_W-16){w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load_data = {{(DATA_W-8){1'b0}}, w_shifted[7:0]};
            3'b101:  w_load_data = {{(DATA_W-16){1'b0}}, w_shifted[15:0]};
            default: w_load_data = dm.dm_rdata_i;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_alu       <= '0;
            r_sdata     <= '0;
            r_wb_data   <= '0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_is_store  <= 1'b0;
            r_funct3    <= '0;
        end else begin
            case (r_state)
                IDLE, WB: begin
                    if (w_capture) begin
                        r_alu       <= exe_alu_result_i;
                        r_sdata     <= exe_store_data_i;
                        r_wb_data   <= exe_alu_result_i;
                        r_rd        <= exe_rd_i;
                        // A read+write combination behaves as a store, so it never writes rd.
                        r_reg_write <= exe_reg_write_i && !exe_mem_write_i;
                        r_is_store  <= exe_mem_write_i;
                        r_funct3    <= exe_funct3_i;
                        r_state     <= (exe_mem_read_i || exe_mem_write_i) ? REQ : WB;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                REQ: begin
                    if (dm.dm_req_ready_i) begin
                        r_state <= r_is_store ? WB : RSP;
                    end
                end
                RSP: begin
                    if (dm.dm_rsp_valid_i) begin
                        r_wb_data <= w_load_data;
                        r_state   <= WB;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
